// File: rtl/fetch_pkg.sv
// Shared constants and the fetch FSM state type for the instruction-fetch slice.
package fetch_pkg;
    localparam int FETCH_AW  = 8;
    localparam int FETCH_IW  = 16;
    localparam int BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FLUSH  = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_buf.sv
// Two-entry prefetch FIFO holding {pc, instr}; the head is always entry 0.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int W = FETCH_AW + FETCH_IW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [1:0]   count,
    output logic [W-1:0] head
);
    logic [W-1:0] entry_reg  [BUF_DEPTH];
    logic [W-1:0] entry_next [BUF_DEPTH];
    logic [1:0]   count_reg, count_next;
    logic         pop_eff, push_eff, slot;

    assign pop_eff  = pop && (count_reg != 2'd0);
    assign push_eff = push && ((count_reg < 2'd2) || pop_eff);
    // Tail slot as seen after this cycle's pop has shifted the queue down.
    assign slot     = (count_reg == 2'd2) || ((count_reg == 2'd1) && !pop_eff);

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = 2'd0;
        end else if (push_eff && !pop_eff) begin
            count_next = count_reg + 2'd1;
        end else if (pop_eff && !push_eff) begin
            count_next = count_reg - 2'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            if (gi < BUF_DEPTH - 1) begin : g_shift
                assign entry_next[gi] = (push_eff && slot == 1'(gi)) ? din :
                                        pop_eff ? entry_reg[gi+1] : entry_reg[gi];
            end else begin : g_last
                assign entry_next[gi] = (push_eff && slot == 1'(gi)) ? din : entry_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 2'd0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            count_reg <= count_next;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                entry_reg[i] <= entry_next[i];
            end
        end
    end

    assign count = count_reg;
    assign head  = entry_reg[0];
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC register, RUN/HALTED/FLUSH FSM and the
// push/pop glue in front of a 2-entry prefetch buffer feeding decode.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int            AW       = FETCH_AW,
    parameter int            IW       = FETCH_IW,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_data,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    input  logic          halt,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [IW-1:0] id_instr,
    output logic [AW-1:0] id_pc,
    output logic [1:0]    fetch_state
);
    fetch_state_t  state_reg, state_next;
    logic [AW-1:0] pc_reg, pc_next;
    logic [1:0]    count;
    logic          pop, push, fetch_en;

    assign pop = id_valid && id_ready;

    // The flush cycle presents nothing; its closing edge already fetches the
    // redirect target, so a redirect costs a single bubble.
    assign fetch_en = (state_reg != HALTED);
    assign push     = fetch_en && !halt && !redirect_valid && ((count < 2'd2) || pop);

    always_comb begin
        state_next = state_reg;
        if (redirect_valid) begin
            state_next = FLUSH;
        end else begin
            case (state_reg)
                RUN:     if (halt) state_next = HALTED;
                HALTED:  if (!halt) state_next = RUN;
                FLUSH:   state_next = halt ? HALTED : RUN;
                default: state_next = RUN;
            endcase
        end
    end

    always_comb begin
        pc_next = pc_reg;
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (push) begin
            pc_next = pc_reg + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    fetch_buf #(
        .W(AW + IW)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop && !redirect_valid),
        .flush (redirect_valid),
        .din   ({pc_reg, imem_data}),
        .count (count),
        .head  ({id_pc, id_instr})
    );

    assign id_valid    = (count != 2'd0);
    assign imem_addr   = pc_reg;
    assign fetch_state = state_reg;
endmodule
